mc_mips_core: RTL and testbench

//  Parametrised multicycle MIPS-I subset core: FSM control, datapath, register file, single unified memory port.
//  The core is the top-level CPU block. The memory port uses a req/ready handshake, so it tolerates variable-latency memory.

---
 rtl/mc_mips_pkg.sv | 15 +
 rtl/mc_mips_if.sv | 8 +
 rtl/mc_mips_regfile.sv | 17 +
 rtl/mc_mips_core.sv | 120 ++++++++++++
 tb/tb_mc_mips_core.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_mips_pkg.sv
// mc_mips_pkg: opcodes, FSM state encoding, ALU op codes and decode helpers for mc_mips_core
package mc_mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL} alu_op_t;
  function automatic alu_op_t alu_sel(input logic [5:0] op, input logic [5:0] fn);
    return op != OP_RTYPE ? ALU_ADD : fn == F_SUB ? ALU_SUB : fn == F_AND ? ALU_AND :
           fn == F_OR ? ALU_OR : fn == F_SLT ? ALU_SLT : fn == F_SLL ? ALU_SLL : ALU_ADD;
  endfunction
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE && fn inside {F_SLL, F_ADD, F_SUB, F_AND, F_OR, F_SLT}) ||
           op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction
endpackage

// File: rtl/mc_mips_if.sv
// mc_mips_if: unified req/ready memory port; the core is master, memory is slave
interface mc_mips_if #(parameter int ADDR_W = 32);
  logic mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mc_mips_regfile.sv
// mc_mips_regfile: 32x32 GPRs, two async read ports, one sync write port, r0 reads as 0
module mc_mips_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);
  logic [31:0] rf_q [32];
  always_ff @(posedge clk)
    if (we_i && waddr_i != 5'd0) rf_q[waddr_i] <= wdata_i;
  assign rdata_a_o = raddr_a_i == 5'd0 ? 32'd0 : rf_q[raddr_a_i];
  assign rdata_b_o = raddr_b_i == 5'd0 ? 32'd0 : rf_q[raddr_b_i];
endmodule

// File: rtl/mc_mips_core.sv
// mc_mips_core: multicycle MIPS-I subset CPU with one req/ready memory port.
// Define MC_MIPS_TRAP_EN to halt on illegal instructions instead of executing them as NOPs.
module mc_mips_core
  import mc_mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] TRAP_CODE = 32'hDEAD_0001
) (
  input  logic        clk,
  input  logic        rst,
  mc_mips_if.master   mem,
  output logic        halted,
  output logic [31:0] trap_cause,
  output logic [31:0] pc_dbg
);
`ifdef MC_MIPS_TRAP_EN
  localparam state_t ILL_NEXT = HALT;
`else
  localparam state_t ILL_NEXT = FETCH;
`endif
  state_t state_q, state_d;
  logic run_q;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] rs_val, rt_val, sext, alu_b, alu_res, addr;
  logic [5:0] op, fn;
  logic hs, is_r;
  alu_op_t aop;
  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];
  assign is_r = op == OP_RTYPE;
  assign sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign hs = mem.mem_req && mem.mem_ready;
  assign aop = alu_sel(op, fn);
  assign alu_b = is_r ? b_q : sext;
  assign alu_res = aop == ALU_SUB ? a_q - alu_b : aop == ALU_AND ? a_q & alu_b : aop == ALU_OR ? a_q | alu_b :
                   aop == ALU_SLT ? {31'd0, $signed(a_q) < $signed(alu_b)} :
                   aop == ALU_SLL ? b_q << ir_q[10:6] : a_q + alu_b;
  mc_mips_regfile u_rf (
    .clk       (clk),
    .we_i      (state_q == WB),
    .waddr_i   (is_r ? ir_q[15:11] : ir_q[20:16]),
    .wdata_i   (op == OP_LW ? mdr_q : alu_q),
    .raddr_a_i (ir_q[25:21]),
    .raddr_b_i (ir_q[20:16]),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val)
  );
  // run_q keeps the port quiet during reset even though the state already reads FETCH
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= FETCH;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= 1'b1;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = hs ? DECODE : FETCH;
      DECODE:  state_d = is_legal(op, fn) ? EXEC : ILL_NEXT;
      EXEC:    state_d = is_r || op == OP_ADDI ? WB : op == OP_LW || op == OP_SW ? MEM : FETCH;
      MEM:     state_d = !hs ? MEM : op == OP_LW ? WB : FETCH;
      WB:      state_d = FETCH;
      default: state_d = HALT;
    endcase
  end
  always_comb begin
    mem.mem_req = run_q && (state_q == FETCH || state_q == MEM);
    mem.mem_we = run_q && state_q == MEM && op == OP_SW;
    addr = state_q == MEM ? alu_q : pc_q;
    mem.mem_addr = addr[ADDR_W-1:0] & ~ADDR_W'(3);
    mem.mem_wdata = b_q;
    halted = state_q == HALT;
    trap_cause = halted ? TRAP_CODE : 32'd0;
    pc_dbg = pc_q;
  end
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    alu_d = alu_q;
    mdr_d = mdr_q;
    case (state_q)
      FETCH: begin
        ir_d = hs ? mem.mem_rdata : ir_q;
        pc_d = hs ? pc_q + 32'd4 : pc_q;
      end
      DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        alu_d = pc_q + (sext << 2);
      end
      EXEC: begin
        alu_d = alu_res;
        pc_d = op == OP_J ? {pc_q[31:28], ir_q[25:0], 2'b00} : op == OP_BEQ && a_q == b_q ? alu_q : pc_q;
      end
      MEM: mdr_d = hs && op == OP_LW ? mem.mem_rdata : mdr_q;
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      pc_q <= RESET_PC;
      ir_q <= 32'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      alu_q <= 32'd0;
      mdr_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      alu_q <= alu_d;
      mdr_q <= mdr_d;
    end
endmodule

// File: tb/tb_mc_mips_core.sv
// tb_mc_mips_core: directed and random programs checked against an instruction-level model of the ISA
module tb_mc_mips_core;
  logic clk = 1'b0, rst = 1'b0;
  logic halted;
  logic [31:0] trap_cause, pc_dbg;
  int checks = 0, errors = 0, cyc = 0, t_prev = 0, exp_prev = 0;
  bit have_prev = 1'b0;
  logic [31:0] dmem [1024];
  logic [31:0] mref [1024];
  logic [31:0] regs [32];
  logic [31:0] pc_m = 32'd0;
  logic [31:0] end_pc;
  mc_mips_if #(.ADDR_W(32)) bus ();
  mc_mips_core dut (.clk(clk), .rst(rst), .mem(bus.master), .halted(halted), .trap_cause(trap_cause), .pc_dbg(pc_dbg));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] ins);
    dmem[a[11:2]] = ins;
    mref[a[11:2]] = ins;
  endtask
  task automatic setr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) regs[r] = v;
  endtask
  function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rd, input int rs, input int rt, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] j_ins(input logic [31:0] t);
    return {6'h02, t[27:2]};
  endfunction
  // ready is randomised while no request is pending: the core must ignore it
  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      bus.mem_ready = 1'($urandom);
      adv();
      n++;
    end
    chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
  endtask
  task automatic xfer(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd, input int w,
                      output logic [31:0] rd);
    logic [31:0] a0, d0;
    a0 = bus.mem_addr;
    d0 = bus.mem_wdata;
    chk({tag, "_we"}, 32'(bus.mem_we), 32'(we));
    chk({tag, "_addr"}, bus.mem_addr, a);
    if (we) chk({tag, "_wdata"}, bus.mem_wdata, wd);
    for (int i = 0; i < w; i++) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      adv();
      chk({tag, "_stall_ctl"}, 32'({bus.mem_req, bus.mem_we}), 32'({1'b1, we}));
      chk({tag, "_stall_addr"}, bus.mem_addr, a0);
      if (we) chk({tag, "_stall_wdata"}, bus.mem_wdata, d0);
    end
    rd = dmem[bus.mem_addr[11:2]];
    if (we) dmem[bus.mem_addr[11:2]] = bus.mem_wdata;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    adv();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
  endtask
  task automatic step(input int wf, input int wm);
    logic [31:0] ins, rd, ea, s, t, npc;
    int base;
    bit memop;
    wait_req("fetch");
    if (have_prev) chk("cycles", 32'(cyc - t_prev), 32'(exp_prev));
    chk("pc_dbg", pc_dbg, pc_m);
    t_prev = cyc;
    ins = mref[pc_m[11:2]];
    xfer("fetch", 1'b0, pc_m, 32'd0, wf, rd);
    s = regs[ins[25:21]];
    t = regs[ins[20:16]];
    ea = s + {{16{ins[15]}}, ins[15:0]};
    npc = pc_m + 32'd4;
    base = 4;
    memop = 1'b0;
    case (ins[31:26])
      6'h00:
        case (ins[5:0])
          6'h20: setr(ins[15:11], s + t);
          6'h22: setr(ins[15:11], s - t);
          6'h24: setr(ins[15:11], s & t);
          6'h25: setr(ins[15:11], s | t);
          6'h2A: setr(ins[15:11], {31'd0, $signed(s) < $signed(t)});
          6'h00: setr(ins[15:11], t << ins[10:6]);
          default: base = 2;
        endcase
      6'h08: setr(ins[20:16], ea);
      6'h23: begin
        base = 5;
        memop = 1'b1;
        wait_req("lw");
        xfer("lw", 1'b0, ea & ~32'd3, 32'd0, wm, rd);
        setr(ins[20:16], mref[ea[11:2]]);
      end
      6'h2B: begin
        memop = 1'b1;
        wait_req("sw");
        xfer("sw", 1'b1, ea & ~32'd3, t, wm, rd);
        mref[ea[11:2]] = t;
      end
      6'h04: begin
        base = 3;
        if (s == t) npc = npc + {{14{ins[15]}}, ins[15:0], 2'b00};
      end
      6'h02: begin
        base = 3;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: base = 2;
    endcase
    exp_prev = base + wf + (memop ? wm : 0);
    have_prev = 1'b1;
    pc_m = npc;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    adv();
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    adv();
    chk("rst_ctl", 32'({bus.mem_req, bus.mem_we, halted}), 32'd0);
    chk("rst_trap", trap_cause, 32'd0);
    chk("rst_pc", pc_dbg, 32'd0);
    rst = 1'b1;
    adv();
    chk("boot_req", 32'(bus.mem_req), 32'd1);
    chk("boot_addr", bus.mem_addr, 32'd0);
    pc_m = 32'd0;
    have_prev = 1'b0;
  endtask
  task automatic gen_random(output logic [31:0] e);
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    logic [31:0] a = 32'd0;
    for (int r = 1; r < 32; r++) begin
      wr(a, i_ins(6'h08, r, 0, 16'($urandom)));
      a += 4;
    end
    for (int i = 0; i < 60; i++) begin
      int k = $urandom_range(0, 7);
      int x = $urandom_range(0, 31);
      int y = $urandom_range(0, 31);
      int z = $urandom_range(0, 31);
      logic [15:0] m = 16'(32'h800 + $urandom_range(0, 32'h7FF));
      wr(a, k < 3 ? r_ins(fns[$urandom_range(0, 5)], x, y, z, $urandom_range(0, 31)) :
            k == 3 ? i_ins(6'h08, x, y, 16'($urandom)) :
            k == 4 ? i_ins(6'h23, x, 0, m) :
            k == 5 ? i_ins(6'h2B, x, 0, m) :
            k == 6 ? i_ins(6'h04, x, $urandom_range(0, 1) ? x : y, 16'($urandom_range(0, 2))) :
            j_ins(a + 32'(4 * $urandom_range(1, 3))));
      a += 4;
    end
    for (int r = 1; r < 32; r++) begin
      wr(a, i_ins(6'h2B, r, 0, 16'(32'hC00 + 4 * r)));
      a += 4;
    end
    e = a;
  endtask
  task automatic load_basic();
    wr(32'h00, i_ins(6'h08, 1, 0, 16'd5));
    wr(32'h04, i_ins(6'h08, 2, 0, 16'd7));
    wr(32'h08, r_ins(6'h20, 3, 1, 2, 0));
    wr(32'h0C, i_ins(6'h2B, 3, 0, 16'h40));
    wr(32'h10, i_ins(6'h23, 4, 0, 16'h40));
    wr(32'h14, i_ins(6'h2B, 4, 0, 16'h44));
    wr(32'h18, i_ins(6'h04, 0, 0, 16'hFFFF));
    wr(32'h40, 32'd0);
    wr(32'h44, 32'd0);
  endtask
  initial begin
    logic [31:0] rd;
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = i >= 512 ? $urandom : 32'd0;
      mref[i] = dmem[i];
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    // zero-wait then 3-wait run of the basic program
    load_basic();
    do_reset();
    repeat (7) step(0, 0);
    chk("mem40", dmem[16], 32'd12);
    chk("mem44_r4", dmem[17], 32'd12);
    load_basic();
    do_reset();
    repeat (7) step(3, 3);
    chk("mem40_wait", dmem[16], 32'd12);
    chk("mem44_wait", dmem[17], 32'd12);
    // taken beq, not-taken beq, j
    wr(32'h000, i_ins(6'h04, 1, 1, 16'd2));
    wr(32'h00C, i_ins(6'h04, 2, 1, 16'd2));
    wr(32'h010, j_ins(32'h100));
    wr(32'h100, i_ins(6'h2B, 1, 0, 16'h48));
    wr(32'h104, i_ins(6'h04, 0, 0, 16'hFFFF));
    do_reset();
    repeat (5) step(0, 0);
    chk("beq_r1_store", dmem[18], 32'd5);
    // reset while a lw is stalled
    wr(32'h00, i_ins(6'h08, 5, 0, 16'h33));
    wr(32'h04, i_ins(6'h23, 5, 0, 16'h800));
    do_reset();
    step(0, 0);
    wait_req("t5_fetch");
    xfer("t5_fetch", 1'b0, 32'h4, 32'd0, 0, rd);
    wait_req("t5_lw");
    adv();
    chk("t5_lw_hold", 32'(bus.mem_req), 32'd1);
    wr(32'h00, i_ins(6'h2B, 5, 0, 16'h4C));
    wr(32'h04, i_ins(6'h04, 0, 0, 16'hFFFF));
    do_reset();
    repeat (2) step(0, 0);
    chk("t5_r5", dmem[19], 32'h33);
    // illegal instructions
    wr(32'h00, i_ins(6'h08, 7, 0, 16'd9));
    wr(32'h04, 32'hFC00_0000);
    wr(32'h08, r_ins(6'h3F, 1, 2, 3, 0));
    wr(32'h0C, i_ins(6'h2B, 7, 0, 16'h50));
    wr(32'h10, i_ins(6'h04, 0, 0, 16'hFFFF));
    do_reset();
    step(0, 0);
`ifdef MC_MIPS_TRAP_EN
    wait_req("trap_fetch");
    xfer("trap_fetch", 1'b0, 32'h4, 32'd0, 0, rd);
    for (int i = 0; i < 8; i++) begin
      adv();
      chk("trap_noreq", 32'(bus.mem_req), 32'd0);
    end
    chk("trap_halted", 32'(halted), 32'd1);
    chk("trap_cause", trap_cause, 32'hDEAD_0001);
    chk("trap_pc", pc_dbg, 32'h8);
`else
    repeat (4) step(0, 0);
    chk("nop_r7", dmem[20], 32'd9);
    chk("nop_halted", 32'(halted), 32'd0);
    chk("nop_trap", trap_cause, 32'd0);
`endif
    // random programs with random memory wait states
    for (int r = 0; r < 3; r++) begin
      int n = 0;
      gen_random(end_pc);
      do_reset();
      while (pc_m < end_pc && n < 400) begin
        step($urandom_range(0, r == 0 ? 0 : 3), $urandom_range(0, r == 0 ? 0 : 3));
        n++;
      end
      chk("rand_done", 32'(pc_m >= end_pc), 32'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
